insn_stream_reader: RTL

Consumer side of the instruction stream FIFO: pops bytes written by the prefetcher and delivers 8-bit or 16-bit little-endian operands to the decoder over a request/response handshake. Tracks the IP of the next unconsumed byte and the length of the current instruction. A prefetcher flush (IP reload) aborts any in-flight request and reloads the tracked IP.

---
 rtl/insn_stream_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/insn_stream_reader.sv
// Consumer side of the instruction stream FIFO: pops bytes and returns 8/16-bit
// little-endian operands to the decoder, tracking the IP and the current instruction length.
module insn_stream_reader (
    input  logic        clk,
    input  logic        reset,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    input  logic        flush,
    input  logic [15:0] new_ip,
    input  logic        req_valid,
    input  logic        req_wide,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic [15:0] ip,
    input  logic        start_insn,
    output logic [3:0]  insn_len,
    output logic [2:0]  state_dbg
);

    // Handshake: a request transfers on a clock edge where req_valid && req_ready && !flush;
    // req_wide is sampled on that edge. The answer is a one-cycle resp_valid pulse with
    // resp_data, and there is no backpressure on the response side.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        WAIT_LO  = 3'd2,
        FETCH_HI = 3'd3,
        WAIT_HI  = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   wide_q;
    logic   accept;
    logic   cap_lo;
    logic   cap_hi;
    logic   capture;

    assign state_dbg = state;
    assign capture   = cap_lo | cap_hi;

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        req_ready  = 1'b0;
        accept     = 1'b0;
        cap_lo     = 1'b0;
        cap_hi     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nxt  = WAIT_LO;
                    end else begin
                        state_nxt  = FETCH_LO;
                    end
                end
            end
            FETCH_LO: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                cap_lo = 1'b1;
                if (!wide_q) begin
                    state_nxt = RESP;
                end else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = WAIT_HI;
                end else begin
                    state_nxt  = FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                cap_hi    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A flush aborts everything in flight, including a byte landing this cycle.
        if (flush) begin
            state_nxt  = IDLE;
            fifo_rd_en = 1'b0;
            accept     = 1'b0;
            cap_lo     = 1'b0;
            cap_hi     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wide_q     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 16'h0000;
            ip         <= 16'h0000;
            insn_len   <= 4'd0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == RESP);
            if (accept) begin
                wide_q <= req_wide;
            end
            if (cap_lo) begin
                resp_data <= {8'h00, fifo_rd_data};
            end else if (cap_hi) begin
                resp_data[15:8] <= fifo_rd_data;
            end
            if (flush) begin
                ip <= new_ip;
            end else if (capture) begin
                ip <= ip + 16'd1;
            end
            // start_insn marks the first byte of a new instruction when it coincides with a capture.
            if (flush) begin
                insn_len <= 4'd0;
            end else if (start_insn) begin
                insn_len <= capture ? 4'd1 : 4'd0;
            end else if (capture && insn_len != 4'd15) begin
                insn_len <= insn_len + 4'd1;
            end
        end
    end

endmodule
